// File: rtl/point_table_loader.sv
// point_table_loader
// Writer side of the 16-entry point table scanned by the line-point counter.
// Table bytes arrive over a valid/ready stream and are stored verbatim in a
// register-file table. START is raised once the table is complete and held
// until the counter reports DONE, after which the loader reopens for filling.
// The counter-side read port is combinational.
//
// Optional feature: define POINT_TABLE_CHECKSUM_EN to require a trailing
// checksum byte (sum mod 2^WIDTH of the table bytes) before START is raised.
// Without the macro there is no checksum state and chk_err is tied low.
module point_table_loader #(
    parameter int DEPTH  = 16,
    parameter int WIDTH  = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [WIDTH-1:0]  in_data,
    output logic              in_ready,
    output logic              START,
    input  logic              DONE,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data,
    output logic [ADDR_W:0]   fill_level,
    output logic              chk_err
);

    typedef enum logic [1:0] {
        S_FILL  = 2'd0,
        S_CHECK = 2'd1,
        S_RUN   = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0]     fill_q, fill_d;
    logic                start_q, start_d;
    logic [WIDTH-1:0]    tbl_q [DEPTH];
    logic [WIDTH-1:0]    tbl_d [DEPTH];
    logic                in_ready_s;
    logic                accept_s;

`ifdef POINT_TABLE_CHECKSUM_EN
    logic [WIDTH-1:0]    sum_q, sum_d;
    logic                chk_err_q, chk_err_d;
`endif

    // Next-state, table write and handshake logic.
    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        fill_d     = fill_q;
        start_d    = start_q;
        tbl_d      = tbl_q;
        in_ready_s = 1'b0;
        accept_s   = 1'b0;
`ifdef POINT_TABLE_CHECKSUM_EN
        sum_d      = sum_q;
        chk_err_d  = 1'b0;
`endif
        case (state_q)
            S_FILL: begin
                // Ready is withheld during the reset cycle itself.
                in_ready_s = ~reset;
                accept_s   = in_valid & in_ready_s;
                if (accept_s) begin
                    tbl_d[wr_ptr_q] = in_data;
                    wr_ptr_d        = wr_ptr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
                    fill_d          = fill_q + {{ADDR_W{1'b0}}, 1'b1};
`ifdef POINT_TABLE_CHECKSUM_EN
                    sum_d           = sum_q + in_data;
`endif
                    if (wr_ptr_q == ADDR_W'(DEPTH - 1)) begin
`ifdef POINT_TABLE_CHECKSUM_EN
                        state_d = S_CHECK;
`else
                        state_d = S_RUN;
                        start_d = 1'b1;
`endif
                    end else begin
                        state_d = S_FILL;
                    end
                end else begin
                    state_d = S_FILL;
                end
            end
`ifdef POINT_TABLE_CHECKSUM_EN
            S_CHECK: begin
                // The byte accepted here is the checksum; it is never stored.
                in_ready_s = ~reset;
                accept_s   = in_valid & in_ready_s;
                if (accept_s) begin
                    if (in_data == sum_q) begin
                        state_d = S_RUN;
                        start_d = 1'b1;
                    end else begin
                        state_d   = S_FILL;
                        chk_err_d = 1'b1;
                        fill_d    = {(ADDR_W+1){1'b0}};
                        sum_d     = {WIDTH{1'b0}};
                    end
                end else begin
                    state_d = S_CHECK;
                end
            end
`endif
            S_RUN: begin
                // Table frozen; START held until the counter reports DONE.
                start_d = 1'b1;
                if (DONE) begin
                    state_d = S_FILL;
                    start_d = 1'b0;
                    fill_d  = {(ADDR_W+1){1'b0}};
`ifdef POINT_TABLE_CHECKSUM_EN
                    sum_d   = {WIDTH{1'b0}};
`endif
                end else begin
                    state_d = S_RUN;
                end
            end
            default: begin
                state_d  = S_FILL;
                start_d  = 1'b0;
                wr_ptr_d = {ADDR_W{1'b0}};
                fill_d   = {(ADDR_W+1){1'b0}};
            end
        endcase
    end

    // State, pointer, level, START and table registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= S_FILL;
            wr_ptr_q <= {ADDR_W{1'b0}};
            fill_q   <= {(ADDR_W+1){1'b0}};
            start_q  <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                tbl_q[i] <= {WIDTH{1'b0}};
            end
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            fill_q   <= fill_d;
            start_q  <= start_d;
            for (int i = 0; i < DEPTH; i++) begin
                tbl_q[i] <= tbl_d[i];
            end
        end
    end

`ifdef POINT_TABLE_CHECKSUM_EN
    // Running checksum and one-cycle mismatch pulse.
    always_ff @(posedge clock) begin
        if (reset) begin
            sum_q     <= {WIDTH{1'b0}};
            chk_err_q <= 1'b0;
        end else begin
            sum_q     <= sum_d;
            chk_err_q <= chk_err_d;
        end
    end

    assign chk_err = chk_err_q;
`else
    assign chk_err = 1'b0;
`endif

    assign in_ready   = in_ready_s;
    assign START      = start_q;
    assign fill_level = fill_q;
    assign rd_data    = tbl_q[rd_addr];

endmodule

// File: tb/tb_point_table_loader.sv
// Directed self-checking bench for point_table_loader.
// Inputs are driven 1 time unit after the rising edge; outputs are checked
// at that same point (well away from the next edge).
module tb_point_table_loader;

    logic       clock;
    logic       reset;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       START;
    logic       DONE;
    logic [3:0] rd_addr;
    logic [7:0] rd_data;
    logic [4:0] fill_level;
    logic       chk_err;

    int checks;
    int errors;

    logic [7:0] tbl1 [16];

    point_table_loader dut (
        .clock      (clock),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .START      (START),
        .DONE       (DONE),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .fill_level (fill_level),
        .chk_err    (chk_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Global time limit so the run can never hang.
    initial begin
        #200000;
        $display("FAIL timeout got running want finished");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Sends the checksum byte when the checksum option is built in.
    task automatic send_sum(input logic [7:0] s);
`ifdef POINT_TABLE_CHECKSUM_EN
        in_valid = 1'b1;
        in_data  = s;
        step();
        in_valid = 1'b0;
`else
        if (s == 8'hFF) begin
            in_valid = 1'b0;
        end
`endif
    endtask

    task automatic load_const(input logic [7:0] v);
        for (int i = 0; i < 16; i++) begin
            in_valid = 1'b1;
            in_data  = v;
            step();
        end
        in_valid = 1'b0;
        send_sum(8'(v * 8'd16));
    endtask

    task automatic done_pulse();
        DONE = 1'b1;
        step();
        DONE = 1'b0;
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        DONE     = 1'b0;
        rd_addr  = 4'd0;
        tbl1 = '{8'd1, 8'd255, 8'd0, 8'd0, 8'd0, 8'd2, 8'd0, 8'd0,
                 8'd0, 8'd2, 8'd255, 8'd5, 8'd0, 8'd2, 8'd0, 8'd2};

        #1;
        chk("rst_cycle_ready", {31'd0, in_ready}, 32'd0);
        step();
        reset = 1'b0;
        #1;
        chk("rst_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_start", {31'd0, START}, 32'd0);
        chk("rst_fill", {27'd0, fill_level}, 32'd0);
        chk("rst_rd", {24'd0, rd_data}, 32'd0);
        chk("rst_chkerr", {31'd0, chk_err}, 32'd0);

        // Test 1: full table streamed back to back.
        for (int i = 0; i < 16; i++) begin
            in_valid = 1'b1;
            in_data  = tbl1[i];
            step();
            if (i == 14) begin
                chk("t1_start_early", {31'd0, START}, 32'd0);
                chk("t1_fill15", {27'd0, fill_level}, 32'd15);
            end
        end
        in_valid = 1'b0;
        send_sum(8'h0C);
        chk("t1_start", {31'd0, START}, 32'd1);
        chk("t1_ready", {31'd0, in_ready}, 32'd0);
        chk("t1_fill", {27'd0, fill_level}, 32'd16);
        rd_addr = 4'd11;
        #1;
        chk("t1_rd11", {24'd0, rd_data}, 32'd5);
        rd_addr = 4'd1;
        #1;
        chk("t1_rd1", {24'd0, rd_data}, 32'd255);

        // Test 2: stream attempts while running are ignored.
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            in_data  = 8'hAA;
            step();
        end
        in_valid = 1'b0;
        rd_addr  = 4'd0;
        #1;
        chk("t2_rd0", {24'd0, rd_data}, 32'd1);
        chk("t2_fill", {27'd0, fill_level}, 32'd16);
        chk("t2_start", {31'd0, START}, 32'd1);

        // Test 3: DONE releases START and a new table is taken.
        done_pulse();
        chk("t3_start", {31'd0, START}, 32'd0);
        chk("t3_fill", {27'd0, fill_level}, 32'd0);
        chk("t3_ready", {31'd0, in_ready}, 32'd1);
        load_const(8'h07);
        chk("t3_start2", {31'd0, START}, 32'd1);
        rd_addr = 4'd0;
        #1;
        chk("t3_rd0", {24'd0, rd_data}, 32'd7);
        rd_addr = 4'd15;
        #1;
        chk("t3_rd15", {24'd0, rd_data}, 32'd7);

        // Test 4: reset in the middle of a fill clears everything.
        done_pulse();
        for (int i = 0; i < 7; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(8'h30 + i);
            step();
        end
        in_valid = 1'b0;
        chk("t4_fill7", {27'd0, fill_level}, 32'd7);
        reset = 1'b1;
        #1;
        chk("t4_rst_ready", {31'd0, in_ready}, 32'd0);
        step();
        reset = 1'b0;
        #1;
        chk("t4_fill", {27'd0, fill_level}, 32'd0);
        chk("t4_start", {31'd0, START}, 32'd0);
        for (int a = 0; a < 16; a++) begin
            rd_addr = 4'(a);
            #1;
            chk("t4_rd_clear", {24'd0, rd_data}, 32'd0);
        end
        load_const(8'h5A);
        chk("t4_start2", {31'd0, START}, 32'd1);

        // Test 5: in_valid toggling; 16 accepts take 31 cycles.
        done_pulse();
        for (int i = 0; i < 31; i++) begin
            in_valid = (i % 2 == 0);
            in_data  = 8'(i);
            step();
            if (i == 29) begin
                chk("t5_start_early", {31'd0, START}, 32'd0);
                chk("t5_fill15", {27'd0, fill_level}, 32'd15);
            end
        end
        in_valid = 1'b0;
        send_sum(8'd240);
        chk("t5_start", {31'd0, START}, 32'd1);
        rd_addr = 4'd15;
        #1;
        chk("t5_rd15", {24'd0, rd_data}, 32'd30);

`ifdef POINT_TABLE_CHECKSUM_EN
        // Test 6: correct and wrong checksum.
        done_pulse();
        for (int i = 0; i < 16; i++) begin
            in_valid = 1'b1;
            in_data  = tbl1[i];
            step();
        end
        chk("t6_check_start", {31'd0, START}, 32'd0);
        chk("t6_check_ready", {31'd0, in_ready}, 32'd1);
        in_data = 8'h0C;
        step();
        in_valid = 1'b0;
        chk("t6_good_start", {31'd0, START}, 32'd1);
        chk("t6_good_err", {31'd0, chk_err}, 32'd0);
        done_pulse();
        for (int i = 0; i < 16; i++) begin
            in_valid = 1'b1;
            in_data  = tbl1[i];
            step();
        end
        in_data = 8'h00;
        step();
        in_valid = 1'b0;
        chk("t6_bad_err", {31'd0, chk_err}, 32'd1);
        chk("t6_bad_start", {31'd0, START}, 32'd0);
        chk("t6_bad_fill", {27'd0, fill_level}, 32'd0);
        rd_addr = 4'd11;
        #1;
        chk("t6_bad_keep", {24'd0, rd_data}, 32'd5);
        step();
        chk("t6_err_pulse", {31'd0, chk_err}, 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
